// File: rtl/relogio_pkg.sv
// Shared types and limits for the time-of-day core: FSM state encoding,
// two-digit BCD type and per-field wrap limits.
package relogio_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        SET_HOUR = 2'd1,
        SET_MIN  = 2'd2
    } tk_state_t;

    typedef logic [7:0] bcd2_t;

    localparam bcd2_t HOUR_MAX = 8'h23;
    localparam bcd2_t MIN_MAX  = 8'h59;
    localparam bcd2_t SEC_MAX  = 8'h59;

    // Plain BCD increment; the caller handles the field-limit wrap.
    function automatic bcd2_t bcd_inc(input bcd2_t v);
        bcd2_t r;
        if (v[3:0] == 4'd9) begin
            r = {v[7:4] + 4'd1, 4'd0};
        end else begin
            r = {v[7:4], v[3:0] + 4'd1};
        end
        return r;
    endfunction

endpackage

// File: rtl/bcd_mod_counter.sv
// Two-digit BCD counter wrapping to 00 after MAX; wrap_o flags the carry
// combinationally so a chain of instances resolves in one cycle.
module bcd_mod_counter
    import relogio_pkg::*;
#(
    parameter bcd2_t MAX = SEC_MAX
) (
    input  logic  clk_i,
    input  logic  rstn_i,
    input  logic  inc_i,
    input  logic  clr_i,
    output bcd2_t val_o,
    output logic  wrap_o
);

    bcd2_t val_r;
    bcd2_t val_next_s;

    assign val_o  = val_r;
    assign wrap_o = inc_i && (val_r == MAX);

    // Next value: clear has priority over increment.
    always_comb begin
        val_next_s = val_r;
        if (clr_i) begin
            val_next_s = 8'h00;
        end else if (inc_i) begin
            if (val_r == MAX) begin
                val_next_s = 8'h00;
            end else begin
                val_next_s = bcd_inc(val_r);
            end
        end else begin
            val_next_s = val_r;
        end
    end

    // Counter register.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            val_r <= 8'h00;
        end else begin
            val_r <= val_next_s;
        end
    end

endmodule

// File: rtl/time_keeper.sv
// Time-of-day core: synchronizes the 1 Hz tick, keeps BCD hh:mm:ss and runs
// the RUN / SET_HOUR / SET_MIN adjustment FSM.
module time_keeper
    import relogio_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk_i,
    input  logic       rstn_i,
    input  logic       tick_i,
    input  logic       mode_i,
    input  logic       inc_i,
    output logic [7:0] hour_o,
    output logic [7:0] min_o,
    output logic [7:0] sec_o,
    output logic [1:0] mode_o,
    output logic       blink_o
);

    logic [SYNC_STAGES-1:0] sync_r;
    logic                   sync_prev_r;
    logic                   mode_d_r;
    logic                   mode_prev_r;
    logic                   inc_d_r;
    logic                   inc_prev_r;
    logic                   tick_p_s;
    logic                   mode_p_s;
    logic                   inc_p_s;
    tk_state_t              state_r;
    tk_state_t              state_next_s;
    logic                   blink_r;
    logic                   blink_next_s;
    logic                   sec_inc_s;
    logic                   min_inc_s;
    logic                   hour_inc_s;
    logic                   sec_clr_s;
    logic                   sec_wrap_s;
    logic                   min_wrap_s;
    logic                   hour_wrap_unused_s;

    assign tick_p_s = sync_r[SYNC_STAGES-1] & ~sync_prev_r;
    assign mode_p_s = mode_d_r & ~mode_prev_r;
    assign inc_p_s  = inc_d_r & ~inc_prev_r;

    // Tick synchronizer and edge-detect / button edge-detect registers.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            sync_r      <= '0;
            sync_prev_r <= 1'b0;
            mode_d_r    <= 1'b0;
            mode_prev_r <= 1'b0;
            inc_d_r     <= 1'b0;
            inc_prev_r  <= 1'b0;
        end else begin
            sync_r      <= {sync_r[SYNC_STAGES-2:0], tick_i};
            sync_prev_r <= sync_r[SYNC_STAGES-1];
            mode_d_r    <= mode_i;
            mode_prev_r <= mode_d_r;
            inc_d_r     <= inc_i;
            inc_prev_r  <= inc_d_r;
        end
    end

    // FSM next state, counter enables and blink; a mode event drops inc.
    always_comb begin
        state_next_s = state_r;
        sec_inc_s    = 1'b0;
        min_inc_s    = 1'b0;
        hour_inc_s   = 1'b0;
        sec_clr_s    = 1'b0;
        case (state_r)
            RUN: begin
                sec_inc_s  = tick_p_s;
                min_inc_s  = sec_wrap_s;
                hour_inc_s = min_wrap_s;
                if (mode_p_s) begin
                    state_next_s = SET_HOUR;
                end else begin
                    state_next_s = RUN;
                end
            end
            SET_HOUR: begin
                hour_inc_s = inc_p_s & ~mode_p_s;
                if (mode_p_s) begin
                    state_next_s = SET_MIN;
                end else begin
                    state_next_s = SET_HOUR;
                end
            end
            SET_MIN: begin
                min_inc_s = inc_p_s & ~mode_p_s;
                if (mode_p_s) begin
                    state_next_s = RUN;
                    sec_clr_s    = 1'b1;
                end else begin
                    state_next_s = SET_MIN;
                end
            end
            default: begin
                state_next_s = RUN;
            end
        endcase
        if (state_next_s == RUN) begin
            blink_next_s = 1'b0;
        end else if (state_r != RUN) begin
            blink_next_s = blink_r ^ tick_p_s;
        end else begin
            blink_next_s = blink_r;
        end
    end

    // FSM state and blink registers.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_r <= RUN;
            blink_r <= 1'b0;
        end else begin
            state_r <= state_next_s;
            blink_r <= blink_next_s;
        end
    end

    bcd_mod_counter #(.MAX(SEC_MAX)) u_sec (
        .clk_i  (clk_i),
        .rstn_i (rstn_i),
        .inc_i  (sec_inc_s),
        .clr_i  (sec_clr_s),
        .val_o  (sec_o),
        .wrap_o (sec_wrap_s)
    );

    bcd_mod_counter #(.MAX(MIN_MAX)) u_min (
        .clk_i  (clk_i),
        .rstn_i (rstn_i),
        .inc_i  (min_inc_s),
        .clr_i  (1'b0),
        .val_o  (min_o),
        .wrap_o (min_wrap_s)
    );

    bcd_mod_counter #(.MAX(HOUR_MAX)) u_hour (
        .clk_i  (clk_i),
        .rstn_i (rstn_i),
        .inc_i  (hour_inc_s),
        .clr_i  (1'b0),
        .val_o  (hour_o),
        .wrap_o (hour_wrap_unused_s)
    );

    assign mode_o  = state_r;
    assign blink_o = blink_r;

endmodule

// File: tb/tb_time_keeper.sv
// Randomized bench for time_keeper against a seconds-of-day reference model,
// plus directed latency, wrap, simultaneous-event and reset checks.
module tb_time_keeper;

    logic       clk_i;
    logic       rstn_i;
    logic       tick_i;
    logic       mode_i;
    logic       inc_i;
    logic [7:0] hour_o;
    logic [7:0] min_o;
    logic [7:0] sec_o;
    logic [1:0] mode_o;
    logic       blink_o;

    int n_chk;
    int n_pass;

    int   m_h;
    int   m_m;
    int   m_s;
    int   m_st;
    logic m_blink;

    time_keeper #(.SYNC_STAGES(2)) dut (
        .clk_i   (clk_i),
        .rstn_i  (rstn_i),
        .tick_i  (tick_i),
        .mode_i  (mode_i),
        .inc_i   (inc_i),
        .hour_o  (hour_o),
        .min_o   (min_o),
        .sec_o   (sec_o),
        .mode_o  (mode_o),
        .blink_o (blink_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] to_bcd(input int v);
        return 8'((v / 10) * 16 + (v % 10));
    endfunction

    task automatic m_reset();
        m_h = 0; m_m = 0; m_s = 0; m_st = 0; m_blink = 1'b0;
    endtask

    task automatic m_tick();
        int t;
        if (m_st == 0) begin
            t   = (m_h * 3600 + m_m * 60 + m_s + 1) % 86400;
            m_h = t / 3600;
            m_m = (t / 60) % 60;
            m_s = t % 60;
        end else begin
            m_blink = ~m_blink;
        end
    endtask

    task automatic m_mode();
        if (m_st == 2) begin
            m_s = 0;
            m_st = 0;
            m_blink = 1'b0;
        end else begin
            m_st = m_st + 1;
        end
    endtask

    task automatic m_inc();
        if (m_st == 1) m_h = (m_h + 1) % 24;
        else if (m_st == 2) m_m = (m_m + 1) % 60;
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".hour"},  32'(hour_o),  32'(to_bcd(m_h)));
        chk({tag, ".min"},   32'(min_o),   32'(to_bcd(m_m)));
        chk({tag, ".sec"},   32'(sec_o),   32'(to_bcd(m_s)));
        chk({tag, ".mode"},  32'(mode_o),  32'(m_st));
        chk({tag, ".blink"}, 32'(blink_o), 32'(m_blink));
    endtask

    // One tick edge; verifies nothing changes at k+1 and the update lands at k+2.
    task automatic tick_timed(input string tag);
        @(posedge clk_i); #1; tick_i = 1'b1;
        @(posedge clk_i);
        @(posedge clk_i); #1;
        check_all({tag, ".early"});
        @(posedge clk_i); #1;
        m_tick();
        check_all(tag);
        tick_i = 1'b0;
        repeat (2) @(posedge clk_i);
        #1;
    endtask

    task automatic tick_pulse();
        @(posedge clk_i); #1; tick_i = 1'b1;
        repeat (3) @(posedge clk_i);
        #1; tick_i = 1'b0;
        repeat (3) @(posedge clk_i);
        #1;
        m_tick();
    endtask

    task automatic press(input logic md, input logic ic, input int hold, input string tag);
        @(posedge clk_i); #1; mode_i = md; inc_i = ic;
        repeat (hold) @(posedge clk_i);
        #1; mode_i = 1'b0; inc_i = 1'b0;
        repeat (3) @(posedge clk_i);
        #1;
        if (md) m_mode();
        else if (ic) m_inc();
        check_all(tag);
    endtask

    task automatic set_time(input int h, input int m);
        int n;
        while (m_st != 1) press(1'b1, 1'b0, 1, "set.mode");
        n = (h - m_h + 24) % 24;
        for (int i = 0; i < n; i++) press(1'b0, 1'b1, 1, "set.inc_h");
        press(1'b1, 1'b0, 1, "set.to_min");
        n = (m - m_m + 60) % 60;
        for (int i = 0; i < n; i++) press(1'b0, 1'b1, 1, "set.inc_m");
        press(1'b1, 1'b0, 1, "set.to_run");
    endtask

    initial begin
        int op;
        n_chk = 0;
        n_pass = 0;
        rstn_i = 1'b0;
        tick_i = 1'b0;
        mode_i = 1'b0;
        inc_i  = 1'b0;
        m_reset();
        repeat (3) @(posedge clk_i);
        #1;
        check_all("reset");
        rstn_i = 1'b1;
        repeat (4) @(posedge clk_i);
        #1;
        check_all("post_reset");

        for (int i = 0; i < 3; i++) tick_timed("tick3");

        // 23:59:58 then the full carry chain.
        set_time(23, 59);
        for (int i = 0; i < 58; i++) tick_pulse();
        check_all("preload");
        tick_timed("to_235959");
        tick_timed("to_000000");

        // Hour wrap at 23, minute wrap at 59 without hour carry.
        press(1'b1, 1'b0, 1, "hr.enter");
        for (int i = 0; i < 25; i++) press(1'b0, 1'b1, 1, "hr.inc");
        chk("hour_after_25", 32'(hour_o), 32'h01);
        press(1'b1, 1'b0, 1, "min.enter");
        for (int i = 0; i < 61; i++) press(1'b0, 1'b1, 1, "min.inc");
        chk("min_after_61", 32'(min_o), 32'h01);
        chk("hour_kept", 32'(hour_o), 32'h01);
        press(1'b1, 1'b0, 1, "back_run");

        // Ticks in SET_HOUR only blink.
        for (int i = 0; i < 5; i++) tick_pulse();
        press(1'b1, 1'b0, 1, "blink.enter");
        for (int i = 0; i < 4; i++) tick_timed("blink.tick");
        press(1'b1, 1'b0, 1, "blink.min");
        tick_pulse();
        check_all("blink.min_tick");
        press(1'b1, 1'b0, 1, "blink.run");
        chk("blink_run_zero", 32'(blink_o), 32'h0);

        // Simultaneous mode+inc in RUN, then a long held inc.
        press(1'b1, 1'b1, 1, "mode_inc");
        press(1'b0, 1'b1, 100, "held_inc");
        press(1'b1, 1'b0, 1, "held.min");
        press(1'b1, 1'b0, 1, "held.run");

        // Tick and mode events land in the same cycle in RUN.
        @(posedge clk_i); #1; tick_i = 1'b1;
        @(posedge clk_i); #1; mode_i = 1'b1;
        repeat (3) @(posedge clk_i);
        #1; tick_i = 1'b0; mode_i = 1'b0;
        repeat (2) @(posedge clk_i);
        #1;
        m_tick();
        m_mode();
        check_all("tick_mode");
        press(1'b1, 1'b0, 1, "tm.min");
        press(1'b1, 1'b0, 1, "tm.run");

        // Randomized mix.
        for (int i = 0; i < 150; i++) begin
            op = int'($urandom_range(0, 8));
            if (op <= 3) begin
                tick_pulse();
                check_all("rnd.tick");
            end else if (op == 4) press(1'b1, 1'b0, 1, "rnd.mode");
            else if (op <= 6) press(1'b0, 1'b1, 1, "rnd.inc");
            else if (op == 7) press(1'b1, 1'b1, int'($urandom_range(1, 4)), "rnd.mode_inc");
            else press(1'b0, 1'b1, int'($urandom_range(2, 20)), "rnd.held_inc");
        end

        // Async reset in SET_MIN at 12:34:56.
        while (m_st != 0) press(1'b1, 1'b0, 1, "rst.to_run");
        set_time(12, 34);
        for (int i = 0; i < 56; i++) tick_pulse();
        press(1'b1, 1'b0, 1, "rst.hr");
        press(1'b1, 1'b0, 1, "rst.min");
        check_all("rst.before");
        @(posedge clk_i); #3; rstn_i = 1'b0;
        #1;
        m_reset();
        check_all("rst.async");
        @(posedge clk_i); #1; rstn_i = 1'b1;
        repeat (2) @(posedge clk_i);
        #1;
        check_all("rst.release");
        tick_timed("rst.tick");
        chk("rst_sec_01", 32'(sec_o), 32'h01);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
